// File: rtl/conv_mac_pipe_pkg.sv
// Shared constants and width helpers for the convolution MAC pipeline.
// Optional feature macro: MAC_RELU_EN (clamps negative results to zero).
package conv_mac_pipe_pkg;

   localparam int unsigned DEF_DATA_W     = 9;
   localparam int unsigned DEF_N_TAPS     = 9;
   localparam int unsigned DEF_NUM_PASSES = 3;
   localparam int unsigned DEF_OUT_W      = 24;

   // Ceiling log2; clog2(1) == 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic int unsigned prod_width(input int unsigned data_w);
      return 2 * data_w;
   endfunction

   function automatic int unsigned sum_width(input int unsigned data_w, input int unsigned n_taps);
      return prod_width(data_w) + clog2(n_taps);
   endfunction

   function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned n_taps,
                                             input int unsigned num_passes, input int unsigned out_w);
      return max_u(sum_width(data_w, n_taps), out_w) + clog2(num_passes) + 1;
   endfunction

   localparam int unsigned DEF_PROD_W = prod_width(DEF_DATA_W);
   localparam int unsigned DEF_SUM_W  = sum_width(DEF_DATA_W, DEF_N_TAPS);
   localparam int unsigned DEF_ACC_W  = acc_width(DEF_DATA_W, DEF_N_TAPS, DEF_NUM_PASSES, DEF_OUT_W);

endpackage

// File: rtl/conv_mac_pipe_if.sv
// Beat input / result output bundle of the convolution MAC pipeline.
// master drives beats and receives results; slave is the MAC engine.
interface conv_mac_pipe_if
   import conv_mac_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned N_TAPS = DEF_N_TAPS,
   parameter int unsigned OUT_W  = DEF_OUT_W
);
   logic                       in_valid;
   logic [N_TAPS*DATA_W-1:0]   in;
   logic [N_TAPS*DATA_W-1:0]   kernel;
   logic [OUT_W-1:0]           bias;
   logic                       out_valid;
   logic [OUT_W-1:0]           out;
   logic                       out_sat;

   modport master (
      output in_valid, in, kernel, bias,
      input  out_valid, out, out_sat
   );

   modport slave (
      input  in_valid, in, kernel, bias,
      output out_valid, out, out_sat
   );
endinterface

// File: rtl/conv_mac_pipe_adder.sv
// One registered level of the MAC adder tree: 2*K operands in, K pair sums out.
module mac_pipe_adder #(
   parameter int unsigned K     = 1,
   parameter int unsigned SUM_W = 22
)(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [2*K*SUM_W-1:0]   ops,
   output logic                   out_valid,
   output logic [K*SUM_W-1:0]     sums
);

   // Register pairwise sums and forward the valid bit one level down the tree.
   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid <= 1'b0;
         sums      <= '0;
      end else begin
         out_valid <= in_valid;
         for (int unsigned j = 0; j < K; j++) begin
            sums[j*SUM_W +: SUM_W] <= ops[(2*j)*SUM_W +: SUM_W] + ops[(2*j+1)*SUM_W +: SUM_W];
         end
      end
   end

endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined signed multiply-accumulate engine for convolution layers.
// Per beat: N_TAPS products -> registered adder tree -> cross-beat accumulator
// over NUM_PASSES beats plus bias -> saturated OUT_W result with one-cycle strobe.
// Optional feature macro: MAC_RELU_EN (negative results forced to zero).
module conv_mac_pipe
   import conv_mac_pipe_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned N_TAPS     = DEF_N_TAPS,
   parameter int unsigned NUM_PASSES = DEF_NUM_PASSES,
   parameter int unsigned OUT_W      = DEF_OUT_W
)(
   input  logic            clock,
   input  logic            reset,
   conv_mac_pipe_if.slave  bus
);

   localparam int unsigned PROD_W = prod_width(DATA_W);
   localparam int unsigned TREE_D = clog2(N_TAPS);
   localparam int unsigned PAD    = 1 << TREE_D;
   localparam int unsigned SUM_W  = sum_width(DATA_W, N_TAPS);
   localparam int unsigned ACC_W  = acc_width(DATA_W, N_TAPS, NUM_PASSES, OUT_W);
   localparam int unsigned PC_W   = (NUM_PASSES > 1) ? clog2(NUM_PASSES) : 1;

   localparam logic [PC_W-1:0] LAST_PC = PC_W'(NUM_PASSES - 1);

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   // ---------------- stage M: products ----------------
   logic signed [PROD_W-1:0] prod_c [N_TAPS];
   logic signed [PROD_W-1:0] prod   [N_TAPS];
   logic                     m_valid;
   logic [PC_W-1:0]          ipc;
   logic signed [OUT_W-1:0]  bias_pipe [TREE_D+1];

   // Full-width signed product of each pixel/weight pair.
   always_comb begin
      for (int unsigned i = 0; i < N_TAPS; i++) begin
         prod_c[i] = PROD_W'($signed(bus.in[i*DATA_W +: DATA_W]))
                   * PROD_W'($signed(bus.kernel[i*DATA_W +: DATA_W]));
      end
   end

   // Register products; capture bias on the first beat of each input-side group
   // and carry it down a delay line that matches the tree depth.
   always_ff @(posedge clock) begin
      if (!reset) begin
         m_valid <= 1'b0;
         ipc     <= '0;
         for (int unsigned i = 0; i < N_TAPS; i++) prod[i] <= '0;
         for (int unsigned j = 0; j <= TREE_D; j++) bias_pipe[j] <= '0;
      end else begin
         m_valid <= bus.in_valid;
         for (int unsigned i = 0; i < N_TAPS; i++) prod[i] <= prod_c[i];
         if (bus.in_valid) begin
            bias_pipe[0] <= (ipc == '0) ? $signed(bus.bias) : '0;
            ipc          <= (ipc == LAST_PC) ? '0 : ipc + PC_W'(1);
         end
         for (int unsigned j = 1; j <= TREE_D; j++) bias_pipe[j] <= bias_pipe[j-1];
      end
   end

   // ---------------- stages T1..T_TREE_D: adder tree ----------------
   // Heap-ordered node array: leaves at PAD..2*PAD-1, root at 1, so every
   // level is a contiguous slice with no unused bits.
   logic [2*PAD-1:1][SUM_W-1:0] node;
   logic [TREE_D:0]             tv;

   assign tv[0] = m_valid;

   for (genvar i = 0; i < PAD; i++) begin : g_leaf
      if (i < N_TAPS) begin : g_tap
         assign node[PAD+i] = SUM_W'(prod[i]);
      end else begin : g_pad
         assign node[PAD+i] = '0;
      end
   end

   for (genvar l = 0; l < TREE_D; l++) begin : g_level
      localparam int unsigned K = PAD >> (l + 1);
      mac_pipe_adder #(
         .K     (K),
         .SUM_W (SUM_W)
      ) u_add (
         .clock     (clock),
         .reset     (reset),
         .in_valid  (tv[l]),
         .ops       (node[4*K-1:2*K]),
         .out_valid (tv[l+1]),
         .sums      (node[2*K-1:K])
      );
   end

   // ---------------- stage A: accumulate, saturate, emit ----------------
   logic signed [SUM_W-1:0] tree;
   logic                    tree_valid;
   logic signed [OUT_W-1:0] bias_d;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum_next;
   logic [PC_W-1:0]         pc;
   logic [OUT_W-1:0]        sat_val;
   logic                    sat_flag;

   assign tree       = node[1];
   assign tree_valid = tv[TREE_D];
   assign bias_d     = bias_pipe[TREE_D];

   // New partial sum: first pass of a group restarts from bias.
   always_comb begin
      if (pc == '0) sum_next = ACC_W'(tree) + ACC_W'(bias_d);
      else          sum_next = acc + ACC_W'(tree);
   end

   // Clamp the group sum into OUT_W, optionally rectified.
   always_comb begin
      sat_val  = OUT_W'(sum_next);
      sat_flag = 1'b0;
      if (sum_next > SAT_MAX) begin
         sat_val  = OUT_W'(SAT_MAX);
         sat_flag = 1'b1;
      end else if (sum_next < SAT_MIN) begin
         sat_val  = OUT_W'(SAT_MIN);
         sat_flag = 1'b1;
      end
`ifdef MAC_RELU_EN
      if (sum_next < 0) begin
         sat_val  = '0;
         sat_flag = 1'b0;
      end
`endif
   end

   // Accumulator, pass counter and registered result with one-cycle strobe.
   always_ff @(posedge clock) begin
      if (!reset) begin
         acc           <= '0;
         pc            <= '0;
         bus.out_valid <= 1'b0;
         bus.out       <= '0;
         bus.out_sat   <= 1'b0;
      end else begin
         bus.out_valid <= 1'b0;
         if (tree_valid) begin
            acc <= sum_next;
            pc  <= (pc == LAST_PC) ? '0 : pc + PC_W'(1);
            if (pc == LAST_PC) begin
               bus.out       <= sat_val;
               bus.out_sat   <= sat_flag;
               bus.out_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Self-checking bench for conv_mac_pipe: three instances (defaults, OUT_W=16,
// NUM_PASSES=1) share one beat stream; a group-level arithmetic model feeds a
// per-instance expected-result queue checked every cycle.
module tb_conv_mac_pipe;
   import conv_mac_pipe_pkg::*;

   localparam int LAT = 6;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   conv_mac_pipe_if #(.DATA_W(9), .N_TAPS(9), .OUT_W(24)) b0();
   conv_mac_pipe_if #(.DATA_W(9), .N_TAPS(9), .OUT_W(16)) b1();
   conv_mac_pipe_if #(.DATA_W(9), .N_TAPS(9), .OUT_W(24)) b2();

   conv_mac_pipe #(.DATA_W(9), .N_TAPS(9), .NUM_PASSES(3), .OUT_W(24))
      u0 (.clock(clock), .reset(reset), .bus(b0.slave));
   conv_mac_pipe #(.DATA_W(9), .N_TAPS(9), .NUM_PASSES(3), .OUT_W(16))
      u1 (.clock(clock), .reset(reset), .bus(b1.slave));
   conv_mac_pipe #(.DATA_W(9), .N_TAPS(9), .NUM_PASSES(1), .OUT_W(24))
      u2 (.clock(clock), .reset(reset), .bus(b2.slave));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit in_rst = 1'b1;
   int last_beat = 0;

   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int     c;
      longint v;
      bit     s;
   } exp_t;

   exp_t   sq [3][$];
   int     np [3] = '{3, 3, 1};
   int     ow [3] = '{24, 16, 24};
   int     pos [3];
   longint part [3];
   longint last_o [3];
   bit     last_s [3];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint sext(input longint x, input int w);
      return (x <<< (64 - w)) >>> (64 - w);
   endfunction

   function automatic void sat_model(input longint s, input int w, output longint v, output bit f);
      longint mx, mn;
      mx = (longint'(1) <<< (w - 1)) - 1;
      mn = -(longint'(1) <<< (w - 1));
      if (s > mx)      begin v = mx; f = 1'b1; end
      else if (s < mn) begin v = mn; f = 1'b1; end
      else             begin v = s;  f = 1'b0; end
`ifdef MAC_RELU_EN
      if (v < 0) begin v = 0; f = 1'b0; end
`endif
   endfunction

   function automatic logic get_ov(input int k);
      case (k)
         0: return b0.out_valid;
         1: return b1.out_valid;
         default: return b2.out_valid;
      endcase
   endfunction

   function automatic longint get_out(input int k);
      case (k)
         0: return longint'($signed(b0.out));
         1: return longint'($signed(b1.out));
         default: return longint'($signed(b2.out));
      endcase
   endfunction

   function automatic logic get_sat(input int k);
      case (k)
         0: return b0.out_sat;
         1: return b1.out_sat;
         default: return b2.out_sat;
      endcase
   endfunction

   // Per-cycle scoreboard check of one instance.
   task automatic mon(input int k);
      exp_t e;
      logic ov;
      longint o;
      logic os;
      ov = get_ov(k);
      o  = get_out(k);
      os = get_sat(k);
      if (ov) begin
         check($sformatf("u%0d_strobe_expected", k), longint'(sq[k].size() != 0), 1);
         if (sq[k].size() != 0) begin
            e = sq[k].pop_front();
            check($sformatf("u%0d_latency", k), cyc, e.c);
            check($sformatf("u%0d_out", k), o, e.v);
            check($sformatf("u%0d_sat", k), longint'(os), longint'(e.s));
         end
         last_o[k] = o;
         last_s[k] = os;
      end else begin
         check($sformatf("u%0d_out_hold", k), o, last_o[k]);
         check($sformatf("u%0d_sat_hold", k), longint'(os), longint'(last_s[k]));
         if (sq[k].size() != 0 && sq[k][0].c < cyc) begin
            check($sformatf("u%0d_missing_strobe_at", k), cyc, sq[k][0].c);
            void'(sq[k].pop_front());
         end
      end
   endtask

   always @(negedge clock) begin
      if (!in_rst) begin
         mon(0);
         mon(1);
         mon(2);
      end
   end

   // Present one beat for a cycle and update the group model of each instance.
   task automatic drive_beat(input int p [9], input int k [9], input int b);
      logic [80:0] vi, vk;
      logic [31:0] bv;
      int t, u;
      longint dot, v;
      bit f;
      exp_t e;
      dot = 0;
      for (int i = 0; i < 9; i++) begin
         t = p[i];
         u = k[i];
         vi[i*9 +: 9] = t[8:0];
         vk[i*9 +: 9] = u[8:0];
         dot += longint'(p[i]) * longint'(k[i]);
      end
      bv = b;
      b0.in = vi; b1.in = vi; b2.in = vi;
      b0.kernel = vk; b1.kernel = vk; b2.kernel = vk;
      b0.bias = bv[23:0]; b1.bias = bv[15:0]; b2.bias = bv[23:0];
      b0.in_valid = 1'b1; b1.in_valid = 1'b1; b2.in_valid = 1'b1;
      last_beat = cyc;
      for (int m = 0; m < 3; m++) begin
         if (pos[m] == 0) part[m] = sext(longint'(b), ow[m]);
         part[m] += dot;
         pos[m]++;
         if (pos[m] == np[m]) begin
            sat_model(part[m], ow[m], v, f);
            e.c = cyc + LAT;
            e.v = v;
            e.s = f;
            sq[m].push_back(e);
            pos[m] = 0;
         end
      end
      @(posedge clock);
      #1;
      b0.in_valid = 1'b0; b1.in_valid = 1'b0; b2.in_valid = 1'b0;
   endtask

   // Idle cycles with garbage on the data lines.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         b0.in = {$urandom, $urandom, $urandom};
         b1.in = b0.in; b2.in = b0.in;
         b0.kernel = {$urandom, $urandom, $urandom};
         b1.kernel = b0.kernel; b2.kernel = b0.kernel;
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      in_rst = 1'b1;
      reset  = 1'b0;
      repeat (n) @(posedge clock);
      #1;
      reset = 1'b1;
      for (int m = 0; m < 3; m++) begin
         pos[m] = 0;
         part[m] = 0;
         sq[m].delete();
         last_o[m] = 0;
         last_s[m] = 1'b0;
      end
      for (int m = 0; m < 3; m++) begin
         check($sformatf("u%0d_rst_out_valid", m), longint'(get_ov(m)), 0);
         check($sformatf("u%0d_rst_out", m), get_out(m), 0);
         check($sformatf("u%0d_rst_out_sat", m), longint'(get_sat(m)), 0);
      end
      in_rst = 1'b0;
   endtask

   task automatic wait_strobe(input int k, output bit found, output int at);
      found = 1'b0;
      at = -1;
      for (int w = 0; w < 20; w++) begin
         @(negedge clock);
         if (get_ov(k)) begin
            found = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic sync();
      @(posedge clock);
      #1;
   endtask

   task automatic fill(output int a [9], input int v);
      for (int i = 0; i < 9; i++) a[i] = v;
   endtask

   typedef struct {
      int     p;
      int     k;
      int     b;
      int     gap;
      longint e0;
      bit     s0;
      longint e1;
      bit     s1;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl [5];
      int pa [9], ka [9];
      bit found;
      int at, at2;
      longint e0, e1;
      bit s0, s1;

      tbl[0] = '{p: 1,    k: 1,    b: 5,    gap: 0, e0: 32,       s0: 0, e1: 32,     s1: 0};
      tbl[1] = '{p: -256, k: -256, b: 0,    gap: 0, e0: 1769472,  s0: 0, e1: 32767,  s1: 1};
      tbl[2] = '{p: 1,    k: 1,    b: 5,    gap: 2, e0: 32,       s0: 0, e1: 32,     s1: 0};
      tbl[3] = '{p: -256, k: 255,  b: 0,    gap: 1, e0: -1762560, s0: 0, e1: -32768, s1: 1};
      tbl[4] = '{p: 255,  k: 255,  b: -100, gap: 0, e0: 1755575,  s0: 0, e1: 32767,  s1: 1};

      b0.in_valid = 1'b0; b1.in_valid = 1'b0; b2.in_valid = 1'b0;
      b0.in = '0; b1.in = '0; b2.in = '0;
      b0.kernel = '0; b1.kernel = '0; b2.kernel = '0;
      b0.bias = '0; b1.bias = '0; b2.bias = '0;
      @(posedge clock);
      #1;
      do_reset(3);
      idle(2);

      // Table: one 3-beat group per record, optional gaps between beats.
      for (int r = 0; r < 5; r++) begin
         fill(pa, tbl[r].p);
         fill(ka, tbl[r].k);
         for (int j = 0; j < 3; j++) begin
            drive_beat(pa, ka, (j == 0) ? tbl[r].b : int'($urandom_range(0, 4000)));
            if (j < 2) idle(tbl[r].gap);
         end
         e0 = tbl[r].e0; s0 = tbl[r].s0;
         e1 = tbl[r].e1; s1 = tbl[r].s1;
`ifdef MAC_RELU_EN
         if (e0 < 0) begin e0 = 0; s0 = 1'b0; end
         if (e1 < 0) begin e1 = 0; s1 = 1'b0; end
`endif
         wait_strobe(0, found, at);
         check($sformatf("tbl%0d_strobe_seen", r), longint'(found), 1);
         if (found) begin
            check($sformatf("tbl%0d_latency", r), at - last_beat, LAT);
            check($sformatf("tbl%0d_u0_out", r), get_out(0), e0);
            check($sformatf("tbl%0d_u0_sat", r), longint'(get_sat(0)), longint'(s0));
            check($sformatf("tbl%0d_u1_out", r), get_out(1), e1);
            check($sformatf("tbl%0d_u1_sat", r), longint'(get_sat(1)), longint'(s1));
         end
         sync();
      end

      // Back-to-back groups: bias only taken from the first beat of each group.
      idle(10);
      fill(pa, 1); fill(ka, 1);
      drive_beat(pa, ka, 0);
      drive_beat(pa, ka, 777);
      drive_beat(pa, ka, -999);
      fill(pa, 2);
      drive_beat(pa, ka, 10);
      drive_beat(pa, ka, 1234);
      drive_beat(pa, ka, -55);
      wait_strobe(0, found, at);
      check("b2b_first_seen", longint'(found), 1);
      check("b2b_first_out", get_out(0), 27);
      wait_strobe(0, found, at2);
      check("b2b_second_seen", longint'(found), 1);
      check("b2b_spacing", at2 - at, 3);
      check("b2b_second_out", get_out(0), 64);
      sync();

      // Reset after beat 2 discards the partial group.
      idle(10);
      fill(pa, 1); fill(ka, 1);
      drive_beat(pa, ka, 5);
      drive_beat(pa, ka, 5);
      do_reset(1);
      idle(10);
      drive_beat(pa, ka, 5);
      drive_beat(pa, ka, 5);
      drive_beat(pa, ka, 5);
      wait_strobe(0, found, at);
      check("post_rst_seen", longint'(found), 1);
      check("post_rst_latency", at - last_beat, LAT);
      check("post_rst_out", get_out(0), 32);
      sync();

      // Single-pass instance: one beat, tap0 = -1*1, bias -7.
      idle(10);
      do_reset(1);
      fill(pa, 0); fill(ka, 1);
      pa[0] = -1;
      drive_beat(pa, ka, -7);
      wait_strobe(2, found, at);
      check("np1_seen", longint'(found), 1);
      check("np1_latency", at - last_beat, LAT);
`ifdef MAC_RELU_EN
      check("np1_out", get_out(2), 0);
`else
      check("np1_out", get_out(2), -8);
`endif
      check("np1_sat", longint'(get_sat(2)), 0);
      sync();
      idle(10);
      do_reset(1);

      // Randomized beats with random gaps; the scoreboard checks every strobe.
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 9; i++) begin
            pa[i] = int'($urandom_range(0, 511)) - 256;
            ka[i] = int'($urandom_range(0, 511)) - 256;
         end
         drive_beat(pa, ka, int'($urandom) >>> 8);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      idle(12);
      for (int m = 0; m < 3; m++) begin
         check($sformatf("u%0d_drained", m), sq[m].size(), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
